// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data SRAM port arbiter.
// Purely declarative: no latency and no flow control of its own.
package riscv_mem_pkg;

  localparam int DEF_AWIDTH       = 12;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = 3;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 3'd7;

  // Operation issued to the SRAM in the previous cycle; drives RVALID steering.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles the I side loses to the D side, saturating at 7.
// Updates one cycle after the grant decision; no backpressure, never stalls.
module arb_starve_cnt
  import riscv_mem_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                i_req,
  input  logic                i_gnt,
  input  logic                d_gnt,
  output logic [STARVE_W-1:0] cnt
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (i_gnt || !i_req) begin
      cnt <= '0;
    end else if (d_gnt && (cnt != STARVE_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-fetch and D load/store onto one single-port SRAM; grants are combinational,
// read data returns 1 cycle after grant; a request simply waits (level held) while not granted.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WEN,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                i_force;
  logic [31:0]         i_rdata_q;
  logic [31:0]         d_rdata_q;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                              D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

  assign i_force = (starve_cnt == LIMIT);

  arb_starve_cnt u_starve (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .i_req (I_REQ),
    .i_gnt (I_GNT),
    .d_gnt (D_GNT),
    .cnt   (starve_cnt)
  );

  always_comb begin
    state_nxt = IDLE;
    I_GNT     = 1'b0;
    D_GNT     = 1'b0;
    MEM_CSN   = 1'b1;
    MEM_WEN   = 1'b1;
    MEM_BE    = 4'h0;
    MEM_ADDR  = '0;
    MEM_DI    = 32'h0;
    // Grants are masked while reset is held so requests cannot leak to the SRAM.
    if (RSTn) begin
      if (I_REQ && (!D_REQ || i_force)) begin
        I_GNT     = 1'b1;
        MEM_CSN   = 1'b0;
        MEM_ADDR  = I_ADDR[AWIDTH+1:2];
        state_nxt = I_RD;
      end else if (D_REQ) begin
        D_GNT     = 1'b1;
        MEM_CSN   = 1'b0;
        MEM_WEN   = D_WEN;
        MEM_BE    = D_BE;
        MEM_ADDR  = D_ADDR[AWIDTH+1:2];
        MEM_DI    = D_WDATA;
        state_nxt = D_WEN ? D_RD : D_WR;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      if (state == I_RD) i_rdata_q <= MEM_DOUT;
      if (state == D_RD) d_rdata_q <= MEM_DOUT;
    end
  end

  // The SRAM output is already registered, so it is forwarded during the valid
  // cycle and the local copy holds it until that port's next read returns.
  assign I_RVALID = (state == I_RD);
  assign D_RVALID = (state == D_RD);
  assign I_RDATA  = I_RVALID ? MEM_DOUT : i_rdata_q;
  assign D_RDATA  = D_RVALID ? MEM_DOUT : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized checks of mem_port_arbiter against a transaction-level model
// with a behavioural 1-cycle-latency byte-writable SRAM attached.
module tb_mem_port_arbiter;

  localparam int AW    = 12;
  localparam int LIM   = 4;
  localparam int DEPTH = 4096;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          I_REQ;
  logic [31:0]   I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [31:0]   I_RDATA;
  logic          D_REQ;
  logic          D_WEN;
  logic [3:0]    D_BE;
  logic [31:0]   D_ADDR;
  logic [31:0]   D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [31:0]   D_RDATA;
  logic          MEM_CSN;
  logic          MEM_WEN;
  logic [3:0]    MEM_BE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DOUT;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AWIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WEN(D_WEN), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 4) return 32'hDEADBEEF;
    if (a == 2) return 32'h11223344;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (nw & mask);
  endfunction

  // Behavioural SRAM: unwritten words read back their init_val pattern.
  logic [31:0] sram [DEPTH];
  bit          sram_wr [DEPTH];

  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (!MEM_WEN) begin
        sram[MEM_ADDR]    <= merge(sram_wr[MEM_ADDR] ? sram[MEM_ADDR] : init_val(int'(MEM_ADDR)),
                                   MEM_DI, MEM_BE);
        sram_wr[MEM_ADDR] <= 1'b1;
      end else begin
        MEM_DOUT <= sram_wr[MEM_ADDR] ? sram[MEM_ADDR] : init_val(int'(MEM_ADDR));
      end
    end
  end

  // Reference model state, kept at transaction level.
  logic [31:0] ref_mem [int];
  int          starve;
  bit          pend_i, pend_d;
  logic [31:0] pend_i_dat, pend_d_dat, exp_i_rdata, exp_d_rdata;
  bit          last_i_gnt, last_d_gnt;
  int          checks, failures;

  function automatic logic [31:0] rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwen,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    bit ei, ed;
    int wa;
    @(negedge CLK);
    RSTn = 1'b1; I_REQ = ir; I_ADDR = ia; D_REQ = dr; D_WEN = dwen;
    D_BE = be; D_ADDR = da; D_WDATA = wd;
    #1;
    if (pend_i) exp_i_rdata = pend_i_dat;
    if (pend_d) exp_d_rdata = pend_d_dat;
    chk("i_rvalid", 32'(I_RVALID), 32'(pend_i));
    chk("d_rvalid", 32'(D_RVALID), 32'(pend_d));
    chk("i_rdata", I_RDATA, exp_i_rdata);
    chk("d_rdata", D_RDATA, exp_d_rdata);
    ei = ir && (!dr || starve == LIM);
    ed = dr && !ei;
    chk("i_gnt", 32'(I_GNT), 32'(ei));
    chk("d_gnt", 32'(D_GNT), 32'(ed));
    chk("mem_csn", 32'(MEM_CSN), (ei || ed) ? 32'd0 : 32'd1);
    wa = 0;
    if (ei) begin
      wa = int'((ia >> 2) % DEPTH);
      chk("mem_wen_i", 32'(MEM_WEN), 32'd1);
      chk("mem_be_i", 32'(MEM_BE), 32'd0);
      chk("mem_addr_i", 32'(MEM_ADDR), 32'(wa));
    end else if (ed) begin
      wa = int'((da >> 2) % DEPTH);
      chk("mem_wen_d", 32'(MEM_WEN), 32'(dwen));
      chk("mem_be_d", 32'(MEM_BE), 32'(be));
      chk("mem_addr_d", 32'(MEM_ADDR), 32'(wa));
      chk("mem_di_d", MEM_DI, wd);
    end else begin
      chk("mem_wen_idle", 32'(MEM_WEN), 32'd1);
      chk("mem_be_idle", 32'(MEM_BE), 32'd0);
      chk("mem_addr_idle", 32'(MEM_ADDR), 32'd0);
      chk("mem_di_idle", MEM_DI, 32'd0);
    end
    last_i_gnt = ei;
    last_d_gnt = ed;
    pend_i = ei;
    pend_d = ed && dwen;
    if (ei) pend_i_dat = rd(wa);
    if (ed && dwen) pend_d_dat = rd(wa);
    if (ed && !dwen) ref_mem[wa] = merge(rd(wa), wd, be);
    if (ei || !ir) starve = 0;
    else if (ed && starve < 7) starve = starve + 1;
  endtask

  task automatic rst_step(input bit ir, input bit dr);
    @(negedge CLK);
    RSTn = 1'b0; I_REQ = ir; D_REQ = dr; I_ADDR = $urandom; D_ADDR = $urandom;
    D_WEN = 1'b1; D_BE = 4'hF; D_WDATA = $urandom;
    #1;
    pend_i = 1'b0; pend_d = 1'b0; exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; starve = 0;
    chk("rst_i_gnt", 32'(I_GNT), 32'd0);
    chk("rst_d_gnt", 32'(D_GNT), 32'd0);
    chk("rst_i_rvalid", 32'(I_RVALID), 32'd0);
    chk("rst_d_rvalid", 32'(D_RVALID), 32'd0);
    chk("rst_i_rdata", I_RDATA, 32'h0);
    chk("rst_d_rdata", D_RDATA, 32'h0);
    chk("rst_mem_csn", 32'(MEM_CSN), 32'd1);
    chk("rst_mem_wen", 32'(MEM_WEN), 32'd1);
    chk("rst_mem_be", 32'(MEM_BE), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; starve = 0;
    pend_i = 1'b0; pend_d = 1'b0;
    pend_i_dat = 32'h0; pend_d_dat = 32'h0; exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    RSTn = 1'b0; I_REQ = 1'b0; I_ADDR = 32'h0; D_REQ = 1'b0; D_WEN = 1'b1;
    D_BE = 4'h0; D_ADDR = 32'h0; D_WDATA = 32'h0;

    rst_step(1'b1, 1'b1);
    rst_step(1'b1, 1'b1);

    // Instruction fetch of word 4.
    step(1, 32'h0000_0010, 0, 1, 4'h0, 32'h0, 32'h0);
    chk("fetch_addr", 32'(MEM_ADDR), 32'd4);
    step(0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    chk("fetch_data", I_RDATA, 32'hDEADBEEF);

    // Full-word write then read back at 0xF00.
    step(0, 32'h0, 1, 0, 4'hF, 32'h0000_0F00, 32'h1234_5678);
    chk("wr_wen", 32'(MEM_WEN), 32'd0);
    step(0, 32'h0, 1, 1, 4'hF, 32'h0000_0F00, 32'h0);
    chk("rd_wen", 32'(MEM_WEN), 32'd1);
    step(0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    chk("wr_rd_data", D_RDATA, 32'h1234_5678);

    // Byte-lane write over word 2.
    step(0, 32'h0, 1, 0, 4'h2, 32'h0000_0008, 32'h0000_AB00);
    step(0, 32'h0, 1, 1, 4'hF, 32'h0000_0008, 32'h0);
    step(0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    chk("byte_merge", D_RDATA, 32'h1122_AB44);

    // Both sides requesting: I wins every fifth cycle.
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h100 + 32'(k * 4), 1, 1, 4'hF, 32'h200 + 32'(k * 4), 32'h0);
      chk("starve_pattern", 32'(last_i_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
    end

    // Alternating single-sided reads keep the port busy every cycle.
    for (int k = 0; k < 8; k++) begin
      step(k % 2 == 0, 32'h40 + 32'(k * 4), k % 2 == 1, 1, 4'hF, 32'h80 + 32'(k * 4), 32'h0);
      chk("b2b_gnt", 32'(I_GNT | D_GNT), 32'd1);
      if (k > 0) chk("b2b_rvalid", 32'(I_RVALID | D_RVALID), 32'd1);
    end
    step(0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);

    // Reset lands on the cycle carrying the fetch's RVALID; reissue after.
    step(1, 32'h0000_0010, 0, 1, 4'h0, 32'h0, 32'h0);
    rst_step(1'b1, 1'b0);
    step(1, 32'h0000_0010, 0, 1, 4'h0, 32'h0, 32'h0);
    chk("post_rst_gnt", 32'(I_GNT), 32'd1);
    step(0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    chk("post_rst_data", I_RDATA, 32'hDEADBEEF);

    // Randomized traffic with occasional resets; upper/lower address bits are noise.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step($urandom_range(0, 3) != 0,
             {20'($urandom), 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)},
             $urandom_range(0, 2) != 0,
             1'($urandom_range(0, 1)),
             4'($urandom),
             {20'($urandom), 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)},
             $urandom);
      end
    end
    step(0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
